seven_seg_arbiter: RTL
======================

SEVEN_SEG_ARBITER -- requirements
Module: seven_seg_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing the display (2..8).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, meaning number of digits per frame, matching the downstream multiplexer.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning the minimum ownership time in clocks (>=1).
REQ-004 SHALL have parameter BLINK_CYCLES, default 12_500_000, meaning the blink half-period in clocks (>=1).
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
  clk_i  in  1  clock; all logic on its rising edge.
  rst_i  in  1  synchronous reset, active-high.
  req_i  in  NUM_REQ  request for display ownership, one bit per requester.
  data_i  in  NUM_REQ x NUM_DIGITS x 4  hex nibbles for each requester.
  dots_i  in  NUM_REQ x NUM_DIGITS  decimal points for each requester.
  blink_i  in  NUM_REQ  blink request for each requester.
  grant_o  out  NUM_REQ  one-hot ownership, or all zero.
  digits_o  out  NUM_DIGITS x 4  nibbles to the 7-segment multiplexer.
  dots_o  out  NUM_DIGITS  dots to the multiplexer.
  blank_o  out  1  display off request to the multiplexer's enable.
  owner_o  out  $clog2(NUM_REQ)  index of the current owner.

Function
REQ-006 SHALL implement an FSM with two states: IDLE and HOLD.
REQ-007 In IDLE with req_i==0, SHALL stay in IDLE with grant_o=0 and blank_o=1.
REQ-008 In IDLE with any req_i set, SHALL pick a winner round-robin, searching from last_owner+1 upward with wrap.
  - On the next cycle: grant_o one-hot on the winner, owner_o=winner, state HOLD, hold counter loaded with HOLD_CYCLES-1.
  - Latency from req_i to grant_o: 1 cycle.
REQ-009 In HOLD, SHALL decrement the hold counter once per cycle, saturating at 0.
REQ-010 In HOLD, if the owner deasserts req_i, SHALL release on the next cycle, whatever the counter value.
  - If another request is pending, grant it directly by round-robin, without passing through IDLE.
  - Otherwise go to IDLE.
REQ-011 In HOLD with counter==0 and another requester pending, SHALL hand over on the next cycle to the round-robin next requester.
  - The counter reloads.
  - grant_o is never zero during a direct handover.
REQ-012 In HOLD with counter==0 and no other request, SHALL keep the current owner with the counter held at 0 (preemptible at any later cycle).
REQ-013 Simultaneous requests SHALL be resolved strictly round-robin: no requester is granted twice while another has been requesting continuously.
REQ-014 digits_o and dots_o SHALL be registered copies of data_i[owner] and dots_i[owner], updated every cycle in HOLD.
  - On the grant cycle they already hold the winner's data sampled at the decision edge.
REQ-015 In IDLE, digits_o and dots_o SHALL hold 0 and blank_o SHALL be 1.
REQ-016 In HOLD, blank_o SHALL be 0 unless the blink function (REQ-021) asserts it.
REQ-017 The hold counter SHALL be $clog2(HOLD_CYCLES+1) bits wide.
  - With HOLD_CYCLES==1, a handover may occur on every cycle.

Reset
REQ-018 While rst_i==1 at a clock edge, SHALL set the following on the next cycle:
  - state=IDLE, grant_o=0, owner_o=0, digits_o=0, dots_o=0, blank_o=1.
  - Hold and blink counters 0, last_owner=NUM_REQ-1, so that requester 0 wins first.
REQ-019 Reset asserted mid-HOLD SHALL drop the grant with no further output update.
  - The first grant after reset follows REQ-008.

Configuration
REQ-020 Macro SEVEN_SEG_ARB_BLINK_EN SHALL select whether blink is compiled in.
REQ-021 With SEVEN_SEG_ARB_BLINK_EN defined, blink SHALL operate as follows:
  - While blink_i[owner]==1 in HOLD, blank_o toggles every BLINK_CYCLES clocks.
  - The first BLINK_CYCLES period is visible (blank_o=0).
  - The blink counter resets on every ownership change.
REQ-022 Without SEVEN_SEG_ARB_BLINK_EN, blink_i SHALL remain a port but be ignored.
  - No blink counter is generated.
  - blank_o depends only on the state.

Structure
REQ-023 The FSM state enum (IDLE, HOLD) SHALL be defined in shared package seven_seg_pkg.
REQ-024 The blank default nibble constant SHALL also be defined in seven_seg_pkg.
REQ-025 Round-robin selection SHALL be a combinational sub-module rr_pick.
  - Inputs: request vector, last index, exclude-owner flag.
  - Outputs: winner index and valid.

Verification (NUM_REQ=4, NUM_DIGITS=4, HOLD_CYCLES=8, BLINK_CYCLES=3)
REQ-026 Single request: after reset, req_i=0100 with data_i[2]=16'h1234 -> next cycle grant_o=0100, owner_o=2, digits_o=16'h1234, blank_o=0.
REQ-027 Round-robin fairness: req_i=1111 held constant -> owner sequence 0,1,2,3,0, each lasting exactly 8 cycles, grant_o never 0.
REQ-028 Early release: owner 1 drops req 3 cycles after grant, with req_i[3]=1 -> grant_o=1000 on the following cycle.
REQ-029 Hold extension: only requester 0 requests for 20 cycles -> grant_o=0001 throughout; req_i[2] then rises -> grant_o=0100 one cycle later.
REQ-030 Reset mid-HOLD: rst_i pulsed 1 cycle while owner is 3 -> grant_o=0, blank_o=1, digits_o=0; then with req_i=1001 -> owner 0 wins.
REQ-031 Blink (macro defined): owner has blink_i=1 -> blank_o pattern 0,0,0,1,1,1,0... Without the macro, blank_o stays 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display arbiter.
//   state_t      : arbiter FSM states (IDLE = nobody owns the display,
//                  HOLD = one requester owns it).
//   BLANK_NIBBLE : nibble driven on every digit while the display is unowned.
package seven_seg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [3:0] BLANK_NIBBLE = 4'h0;

endpackage

// File: rtl/seven_seg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Scans the request vector starting at last+1 and wrapping around; the index
// `last` itself is the final candidate and is skipped entirely when excl is set
// (used while `last` is the current owner and must not win again).
// Ports:
//   req    in  NUM_REQ          request vector
//   last   in  $clog2(NUM_REQ)  index granted most recently
//   excl   in  1                exclude `last` from the search
//   winner out $clog2(NUM_REQ)  selected index (0 when valid is low)
//   valid  out 1                a winner was found
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    input  logic                       excl,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);
    localparam int IDXW = $clog2(NUM_REQ);

    int              idx;
    logic [IDXW-1:0] cand;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx  = (int'(last) + i) % NUM_REQ;
            cand = IDXW'(idx);
            if (!valid && req[cand] && !(excl && (cand == last))) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_arbiter.sv
// seven_seg_arbiter: shares one multiplexed 7-segment display among NUM_REQ
// requesters. A requester that wins keeps the display for at least HOLD_CYCLES
// clocks unless it lets go earlier; after that it is preempted by any other
// requester, chosen round-robin. All outputs are registered.
// Optional feature: define SEVEN_SEG_ARB_BLINK_EN to compile in blinking
// (blank_o toggles every BLINK_CYCLES clocks while the owner's blink_i is set).
// Ports:
//   clk_i    in  1                     clock, rising edge
//   rst_i    in  1                     synchronous reset, active-high
//   req_i    in  NUM_REQ               ownership requests
//   data_i   in  NUM_REQ*NUM_DIGITS*4  nibbles, requester r at [r*NUM_DIGITS*4 +: NUM_DIGITS*4]
//   dots_i   in  NUM_REQ*NUM_DIGITS    decimal points, requester r at [r*NUM_DIGITS +: NUM_DIGITS]
//   blink_i  in  NUM_REQ               blink request per requester
//   grant_o  out NUM_REQ               one-hot owner, or zero when idle
//   digits_o out NUM_DIGITS*4          owner's nibbles to the multiplexer
//   dots_o   out NUM_DIGITS            owner's dots to the multiplexer
//   blank_o  out 1                     display-off request
//   owner_o  out $clog2(NUM_REQ)       index of the current owner
module seven_seg_arbiter
    import seven_seg_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int NUM_DIGITS   = 4,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ-1:0]                 req_i,
    input  logic [NUM_REQ*NUM_DIGITS*4-1:0]    data_i,
    input  logic [NUM_REQ*NUM_DIGITS-1:0]      dots_i,
    input  logic [NUM_REQ-1:0]                 blink_i,
    output logic [NUM_REQ-1:0]                 grant_o,
    output logic [NUM_DIGITS*4-1:0]            digits_o,
    output logic [NUM_DIGITS-1:0]              dots_o,
    output logic                               blank_o,
    output logic [$clog2(NUM_REQ)-1:0]         owner_o
);
    localparam int              IDXW      = $clog2(NUM_REQ);
    localparam int              DW        = NUM_DIGITS * 4;
    localparam int              CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    state_t          state, state_nx;
    logic [IDXW-1:0] last_owner, last_nx, owner_nx;
    logic [CW-1:0]   hold_cnt, cnt_nx;
    logic            take;
    logic [IDXW-1:0] pick_idx;
    logic            pick_vld;
    logic [NUM_REQ-1:0] grant_nx;
    logic            blank_hold;

    logic [DW-1:0]         data_arr [NUM_REQ];
    logic [NUM_DIGITS-1:0] dots_arr [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
        assign data_arr[r] = data_i[r*DW +: DW];
        assign dots_arr[r] = dots_i[r*NUM_DIGITS +: NUM_DIGITS];
    end

    // In HOLD last_owner equals the current owner, so excluding it lets the
    // same picker serve both the idle grant and the preemption/release search.
    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (req_i),
        .last   (last_owner),
        .excl   (state == HOLD),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    always_comb begin
        state_nx = state;
        owner_nx = owner_o;
        last_nx  = last_owner;
        cnt_nx   = hold_cnt;
        take     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nx = HOLD;
                    take     = 1'b1;
                end
            end
            HOLD: begin
                if (!req_i[owner_o] || (hold_cnt == '0)) begin
                    if (pick_vld) begin
                        take = 1'b1;
                    end else if (!req_i[owner_o]) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                    // else: hold time expired but nobody else wants the
                    // display; keep it with the counter parked at zero.
                end else begin
                    cnt_nx = hold_cnt - CW'(1);
                end
            end
        endcase
        if (take) begin
            owner_nx = pick_idx;
            last_nx  = pick_idx;
            cnt_nx   = HOLD_LOAD;
        end
        grant_nx = '0;
        if (state_nx == HOLD) begin
            grant_nx[owner_nx] = 1'b1;
        end
    end

`ifdef SEVEN_SEG_ARB_BLINK_EN
    localparam int            BW         = $clog2(BLINK_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] blink_cnt, blink_cnt_nx;
    logic          phase, phase_nx;

    // phase 0 = visible half-period, phase 1 = blanked half-period. Every new
    // ownership starts in a fresh visible half-period.
    always_comb begin
        blink_cnt_nx = '0;
        phase_nx     = 1'b0;
        if (!take && (state_nx == HOLD)) begin
            if (blink_cnt == BLINK_LAST) begin
                phase_nx = ~phase;
            end else begin
                blink_cnt_nx = blink_cnt + BW'(1);
                phase_nx     = phase;
            end
        end
    end

    assign blank_hold = phase_nx & blink_i[owner_nx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt_nx;
            phase     <= phase_nx;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink_i;
    assign blank_hold   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner_o    <= '0;
            last_owner <= IDXW'(NUM_REQ - 1);
            hold_cnt   <= '0;
            grant_o    <= '0;
            digits_o   <= {NUM_DIGITS{BLANK_NIBBLE}};
            dots_o     <= '0;
            blank_o    <= 1'b1;
        end else begin
            state      <= state_nx;
            owner_o    <= owner_nx;
            last_owner <= last_nx;
            hold_cnt   <= cnt_nx;
            grant_o    <= grant_nx;
            if (state_nx == HOLD) begin
                digits_o <= data_arr[owner_nx];
                dots_o   <= dots_arr[owner_nx];
                blank_o  <= blank_hold;
            end else begin
                digits_o <= {NUM_DIGITS{BLANK_NIBBLE}};
                dots_o   <= '0;
                blank_o  <= 1'b1;
            end
        end
    end

endmodule
